// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : riscv_decode_stage
// Purpose  : RV32I/RV64I decode stage between fetch and issue. Fetched words
//            are buffered in a DEPTH-entry in-order queue; the head entry is
//            decoded combinationally and captured into a registered output
//            stage guarded by a valid/ready handshake.
// Ports    : clk, rst_n (async, active-low), flush (sync discard)
//            in_valid/in_ready/in_dword/in_pc      - fetch side
//            out_valid/out_ready/out_*              - issue side
//            count                                  - queue occupancy
//                                                     (output stage excluded)
// Params   : XLEN  - 32 or 64; immediate/pc width and RV64 legality
//            DEPTH - queue entries, power of two, >= 2
// Revision : 1.0 - initial release
// ============================================================================
module riscv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_dword,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [2:0]              out_itype,
  output logic [6:0]              out_opcode,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic [XLEN-1:0]         out_imm,
  output logic [9:0]              out_alu_func,
  output logic [2:0]              out_width,
  output logic [2:0]              out_branch,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int              c_PTR_W = $clog2(DEPTH);
  localparam int              c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam bit              c_RV64  = (XLEN == 64);

  // Major opcodes
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  // Instruction format codes reported on out_itype
  localparam logic [2:0] c_IT_R  = 3'd0;
  localparam logic [2:0] c_IT_I  = 3'd1;
  localparam logic [2:0] c_IT_S  = 3'd2;
  localparam logic [2:0] c_IT_SB = 3'd3;
  localparam logic [2:0] c_IT_U  = 3'd4;
  localparam logic [2:0] c_IT_UJ = 3'd5;

  localparam logic [9:0] c_ALU_SRAI = 10'h105;

  // --------------------------------------------------------------------------
  // Queue storage and control
  // --------------------------------------------------------------------------
  logic [31:0]        r_mem_word [DEPTH];
  logic [XLEN-1:0]    r_mem_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // in_ready looks only at the registered count, so it never depends
  // combinationally on out_ready.
  assign in_ready = (r_count < c_DEPTH);
  assign count    = r_count;

  assign w_push = in_valid && in_ready;
  // The head moves into the output stage whenever that stage is empty or
  // being drained in this same cycle.
  assign w_pop  = (r_count != '0) && (!out_valid || out_ready);

  // Storage array carries no reset: an entry is only read after it has been
  // written, and the pointers/count define what is live.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_word[r_wr_ptr] <= in_dword;
      r_mem_pc[r_wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Head-entry field extraction
  // --------------------------------------------------------------------------
  logic [31:0]     w_d;
  logic [XLEN-1:0] w_head_pc;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd_f;
  logic [4:0]      w_rs1_f;
  logic [4:0]      w_rs2_f;

  assign w_d       = r_mem_word[r_rd_ptr];
  assign w_head_pc = r_mem_pc[r_rd_ptr];
  assign w_op      = w_d[6:0];
  assign w_rd_f    = w_d[11:7];
  assign w_f3      = w_d[14:12];
  assign w_rs1_f   = w_d[19:15];
  assign w_rs2_f   = w_d[24:20];
  assign w_f7      = w_d[31:25];

  // Immediates, sign-extended to XLEN through signed size casts.
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_imm_i = XLEN'($signed(w_d[31:20]));
  assign w_imm_s = XLEN'($signed({w_d[31:25], w_d[11:7]}));
  assign w_imm_b = XLEN'($signed({w_d[31], w_d[7], w_d[30:25], w_d[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({w_d[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({w_d[31], w_d[19:12], w_d[20], w_d[30:21], 1'b0}));

  // Shift-immediate upper bits: shamt is 5 bits on RV32 and 6 bits on RV64,
  // so the field that must be 0 (or the SRAI marker) shrinks by one bit.
  logic w_shamt_ok;
  generate
    if (c_RV64) begin : g_shamt_rv64
      assign w_shamt_ok = (w_d[31:26] == 6'b000000) ||
                          ((w_d[31:26] == 6'b010000) && (w_f3 == 3'b101));
    end else begin : g_shamt_rv32
      assign w_shamt_ok = (w_d[31:25] == 7'b0000000) ||
                          ((w_d[31:25] == 7'b0100000) && (w_f3 == 3'b101));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Combinational decode of the head entry
  // --------------------------------------------------------------------------
  logic [2:0]      w_itype;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;
  logic [9:0]      w_alu;
  logic [2:0]      w_width;
  logic [2:0]      w_branch;
  logic            w_illegal;

  always_comb begin
    w_itype   = c_IT_R;
    w_rs1     = '0;
    w_rs2     = '0;
    w_rd      = '0;
    w_imm     = '0;
    w_alu     = '0;
    w_width   = 3'b010;
    w_branch  = '0;
    w_illegal = 1'b0;

    case (w_op)
      c_OP_R: begin
        w_itype = c_IT_R;
        w_rs1   = w_rs1_f;
        w_rs2   = w_rs2_f;
        w_rd    = w_rd_f;
        w_alu   = {w_f7, w_f3};
        // Only base ops (func7=0) and SUB/SRA (func7=0100000) exist.
        if (!((w_f7 == 7'b0000000) ||
              ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))))) begin
          w_illegal = 1'b1;
        end
      end
      c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
        w_itype = c_IT_I;
        w_rs1   = w_rs1_f;
        w_rd    = w_rd_f;
        w_imm   = w_imm_i;
        w_alu   = {7'b0, w_f3};
        if (w_op == c_OP_IMM) begin
          if ((w_f3 == 3'b101) && w_d[30]) w_alu = c_ALU_SRAI;
          if (((w_f3 == 3'b001) || (w_f3 == 3'b101)) && !w_shamt_ok) w_illegal = 1'b1;
        end
        if (w_op == c_OP_LOAD) begin
          w_width = w_f3;
          // 111 never exists; LD (011) and LWU (110) are RV64-only.
          if ((w_f3 == 3'b111) ||
              (!c_RV64 && ((w_f3 == 3'b011) || (w_f3 == 3'b110)))) begin
            w_illegal = 1'b1;
          end
        end
        if ((w_op == c_OP_JALR) && (w_f3 != 3'b000)) w_illegal = 1'b1;
      end
      c_OP_STORE: begin
        w_itype = c_IT_S;
        w_rs1   = w_rs1_f;
        w_rs2   = w_rs2_f;
        w_imm   = w_imm_s;
        w_width = w_f3;
        if (c_RV64 ? (w_f3 > 3'b011) : (w_f3 > 3'b010)) w_illegal = 1'b1;
      end
      c_OP_BRANCH: begin
        w_itype  = c_IT_SB;
        w_rs1    = w_rs1_f;
        w_rs2    = w_rs2_f;
        w_imm    = w_imm_b;
        w_branch = w_f3;
        if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) w_illegal = 1'b1;
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_itype = c_IT_U;
        w_rd    = w_rd_f;
        w_imm   = w_imm_u;
      end
      c_OP_JAL: begin
        w_itype = c_IT_UJ;
        w_rd    = w_rd_f;
        w_imm   = w_imm_j;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase

    // Compressed or malformed words never carry 2'b11 in the low bits.
    if (w_d[1:0] != 2'b11) w_illegal = 1'b1;

    // An illegal word only reports its pc, opcode and the illegal flag.
    if (w_illegal) begin
      w_itype  = '0;
      w_rs1    = '0;
      w_rs2    = '0;
      w_rd     = '0;
      w_imm    = '0;
      w_alu    = '0;
      w_width  = '0;
      w_branch = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_itype    <= '0;
      out_opcode   <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_imm      <= '0;
      out_alu_func <= '0;
      out_width    <= '0;
      out_branch   <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_pop) begin
      out_valid    <= 1'b1;
      out_pc       <= w_head_pc;
      out_itype    <= w_itype;
      out_opcode   <= w_op;
      out_rs1      <= w_rs1;
      out_rs2      <= w_rs2;
      out_rd       <= w_rd;
      out_imm      <= w_imm;
      out_alu_func <= w_alu;
      out_width    <= w_width;
      out_branch   <= w_branch;
      out_illegal  <= w_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_decode_stage
// Purpose  : Self-checking bench for riscv_decode_stage. An RV32 instance and
//            an RV64 instance share the clock and reset; expected decode
//            results come from an arithmetic reference decoder and a queue
//            scoreboard of accepted words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_decode_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_dword = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [2:0]  out_itype;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [9:0]  out_alu_func;
  logic [2:0]  out_width, out_branch;
  logic        out_illegal;
  logic [2:0]  count;

  logic        flush64 = 1'b0;
  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_dword64 = '0;
  logic [63:0] in_pc64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic [63:0] out_pc64;
  logic [2:0]  out_itype64;
  logic [6:0]  out_opcode64;
  logic [4:0]  out_rs1_64, out_rs2_64, out_rd64;
  logic [63:0] out_imm64;
  logic [9:0]  out_alu_func64;
  logic [2:0]  out_width64, out_branch64;
  logic        out_illegal64;
  logic [2:0]  count64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_dword(in_dword), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_itype(out_itype), .out_opcode(out_opcode),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_func(out_alu_func), .out_width(out_width),
    .out_branch(out_branch), .out_illegal(out_illegal), .count(count)
  );

  riscv_decode_stage #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_dword(in_dword64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(out_pc64),
    .out_itype(out_itype64), .out_opcode(out_opcode64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd64),
    .out_imm(out_imm64), .out_alu_func(out_alu_func64), .out_width(out_width64),
    .out_branch(out_branch64), .out_illegal(out_illegal64), .count(count64)
  );

  // Packed view of every decode field: {itype, opcode, rs1, rs2, rd, imm64,
  // alu_func, width, branch, illegal}. The RV32 imm is zero-padded to 64.
  logic [105:0] act32, act64;
  assign act32 = {out_itype, out_opcode, out_rs1, out_rs2, out_rd, 32'h0, out_imm,
                  out_alu_func, out_width, out_branch, out_illegal};
  assign act64 = {out_itype64, out_opcode64, out_rs1_64, out_rs2_64, out_rd64, out_imm64,
                  out_alu_func64, out_width64, out_branch64, out_illegal64};

  // Reference decoder built from the instruction-set rules with integer
  // arithmetic for the immediates.
  function automatic logic [105:0] ref_decode(input logic [31:0] w, input bit rv64);
    logic [2:0] itype, f3, width, br;
    logic [4:0] rs1, rs2, rd;
    logic [9:0] alu;
    logic [6:0] op, f7;
    longint     imm;
    int         i32, hi, upper, sra_mark;
    bit         ill;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    itype = 3'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; alu = 10'd0;
    width = 3'b010; br = 3'd0; imm = 0; ill = 1'b0;
    case (op)
      7'h33: begin
        rs1 = w[19:15]; rs2 = w[24:20]; rd = w[11:7]; alu = {f7, f3};
        ill = !((f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13, 7'h03, 7'h67: begin
        itype = 3'd1; rs1 = w[19:15]; rd = w[11:7]; alu = {7'd0, f3};
        i32 = $signed(w) >>> 20;
        imm = longint'(i32);
        if (op == 7'h13) begin
          if (f3 == 3'd5 && w[30]) alu = 10'h105;
          if (f3 == 3'd1 || f3 == 3'd5) begin
            upper    = rv64 ? int'(w[31:26]) : int'(w[31:25]);
            sra_mark = rv64 ? 16 : 32;
            ill = !(upper == 0 || (upper == sra_mark && f3 == 3'd5));
          end
        end
        if (op == 7'h03) begin
          width = f3;
          ill = (f3 == 3'd7) || (!rv64 && (f3 == 3'd3 || f3 == 3'd6));
        end
        if (op == 7'h67) ill = (f3 != 3'd0);
      end
      7'h23: begin
        itype = 3'd2; rs1 = w[19:15]; rs2 = w[24:20]; width = f3;
        hi  = $signed(w) >>> 25;
        i32 = hi * 32 + w[11:7];
        imm = longint'(i32);
        ill = rv64 ? (f3 > 3'd3) : (f3 > 3'd2);
      end
      7'h63: begin
        itype = 3'd3; rs1 = w[19:15]; rs2 = w[24:20]; br = f3;
        i32 = (w[31] ? -4096 : 0) + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
        imm = longint'(i32);
        ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h37, 7'h17: begin
        itype = 3'd4; rd = w[11:7];
        i32 = w & 32'hFFFFF000;
        imm = longint'(i32);
      end
      7'h6F: begin
        itype = 3'd5; rd = w[11:7];
        i32 = (w[31] ? -(1 << 20) : 0) + w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2;
        imm = longint'(i32);
      end
      default: ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      itype = 3'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; alu = 10'd0;
      width = 3'd0; br = 3'd0; imm = 0;
    end
    if (!rv64) imm = imm & 64'h0000_0000_FFFF_FFFF;
    return {itype, op, rs1, rs2, rd, 64'(imm), alu, width, br, ill};
  endfunction

  // Random word biased toward the recognised opcodes and shift/R corners.
  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    logic [6:0]  ops [9];
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = ops[k];
    if ((k == 0 || k == 1) && ($urandom % 2 == 0)) begin
      w[31:25] = ($urandom % 2 == 0) ? 7'b0000000 : 7'b0100000;
      if (k == 1) w[14:12] = ($urandom % 2 == 0) ? 3'b001 : 3'b101;
    end
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_dword = 32'h0000_0013; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (act32 !== 106'd0 || out_pc !== 32'd0) begin
      bad++; $display("FAIL reset_fields got=%h pc=%h want=0", act32, out_pc); end
    total++; if (count64 !== 3'd0 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      bad++; $display("FAIL reset_rv64 got count=%0d valid=%b ready=%b want 0/0/1", count64, out_valid64, in_ready64); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode_table();
    logic [31:0] words [10];
    logic [31:0] pc;
    words = '{32'h002081B3, 32'hFFF00093, 32'h4032D293, 32'hFE208EE3, 32'h123450B7,
              32'h00000000, 32'hF000F033, 32'h0040A000, 32'h0000B083, 32'h0020A423};
    for (int i = 0; i < 10; i++) begin
      pc = ($urandom & 32'hFFFF_FFFC);
      in_valid = 1'b1; in_dword = words[i]; in_pc = pc; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || count !== 3'd1) begin
        bad++; $display("FAIL latency_early[%0d] got valid=%b count=%0d want 0/1", i, out_valid, count); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin
        bad++; $display("FAIL latency_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (act32 !== ref_decode(words[i], 1'b0) || out_pc !== pc) begin
        bad++; $display("FAIL decode32[%0d] word=%h got=%h pc=%h want=%h pc=%h",
                        i, words[i], act32, out_pc, ref_decode(words[i], 1'b0), pc); end
      case (i)
        0: begin total++; if ({out_itype, out_rs1, out_rs2, out_rd, out_alu_func, out_imm} !== {3'd0, 5'd1, 5'd2, 5'd3, 10'h000, 32'd0}) begin
             bad++; $display("FAIL add_fields got it=%0d rs1=%0d rs2=%0d rd=%0d", out_itype, out_rs1, out_rs2, out_rd); end end
        1: begin total++; if (out_imm !== 32'hFFFF_FFFF || out_itype !== 3'd1 || out_rd !== 5'd1) begin
             bad++; $display("FAIL addi_imm got=%h want=ffffffff", out_imm); end end
        2: begin total++; if (out_alu_func !== 10'h105 || out_imm[4:0] !== 5'd3) begin
             bad++; $display("FAIL srai got alu=%h sh=%0d want 105/3", out_alu_func, out_imm[4:0]); end end
        3: begin total++; if (out_imm !== 32'hFFFF_FFFC || out_itype !== 3'd3 || out_rd !== 5'd0) begin
             bad++; $display("FAIL beq_imm got=%h want=fffffffc", out_imm); end end
        4: begin total++; if (out_imm !== 32'h1234_5000 || out_itype !== 3'd4) begin
             bad++; $display("FAIL lui_imm got=%h want=12345000", out_imm); end end
        5, 6, 7, 8: begin total++; if (out_illegal !== 1'b1 || out_rs1 !== 5'd0 || out_imm !== 32'd0) begin
             bad++; $display("FAIL illegal32[%0d] got ill=%b imm=%h want 1/0", i, out_illegal, out_imm); end end
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [6];
    logic [31:0] p [6];
    int acc, seen, rel;
    for (int i = 0; i < 6; i++) begin
      w[i] = gen_word();
      p[i] = 32'h1000 + i * 4;
    end
    acc = 0; seen = 0;
    for (int c = 0; c < 8; c++) begin
      out_ready = 1'b0;
      if (acc < 6) begin in_valid = 1'b1; in_dword = w[acc]; in_pc = p[acc]; end
      else in_valid = 1'b0;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    total++; if (acc !== 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", acc); end
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full got count=%0d ready=%b want 4/0", count, in_ready); end
    total++; if (out_valid !== 1'b1 || out_pc !== p[0]) begin
      bad++; $display("FAIL bp_hold got valid=%b pc=%h want 1/%h", out_valid, out_pc, p[0]); end
    rel = 0;
    while (rel < 20 && seen < 6) begin
      out_ready = 1'b1;
      if (rel == 1) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b want=1", in_ready); end
      end
      if (acc < 6) begin in_valid = 1'b1; in_dword = w[acc]; in_pc = p[acc]; end
      else in_valid = 1'b0;
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        total++; if (out_pc !== p[seen] || act32 !== ref_decode(w[seen], 1'b0)) begin
          bad++; $display("FAIL bp_order[%0d] got pc=%h dec=%h want pc=%h dec=%h",
                          seen, out_pc, act32, p[seen], ref_decode(w[seen], 1'b0)); end
        if (seen == 4) begin
          total++; if (rel !== 4) begin bad++; $display("FAIL bp_rate got cycle=%0d want=4", rel); end
        end
        seen++;
      end
      @(negedge clk);
      rel++;
    end
    in_valid = 1'b0;
    total++; if (seen !== 6) begin bad++; $display("FAIL bp_drain got=%0d want=6", seen); end
  endtask

  task automatic test_flush(input bit use_reset);
    logic [31:0] fw;
    int stale;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dword = gen_word(); in_pc = 32'h2000 + i * 4;
      @(negedge clk);
    end
    total++; if (count !== 3'd3 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_pre[%0d] got count=%0d valid=%b want 3/1", use_reset, count, out_valid); end
    in_valid = 1'b1; in_dword = 32'h0000_0013; in_pc = 32'hDEAD_0000;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL async_reset got count=%0d valid=%b want 0/0", count, out_valid); end
    end else begin
      flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_post[%0d] got count=%0d valid=%b ready=%b want 0/0/1",
                      use_reset, count, out_valid, in_ready); end
    out_ready = 1'b1; stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL flush_stale[%0d] got=%0d want=0", use_reset, stale); end
    fw = gen_word();
    in_valid = 1'b1; in_dword = fw; in_pc = 32'h3000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 || act32 !== ref_decode(fw, 1'b0)) begin
      bad++; $display("FAIL flush_restart[%0d] got valid=%b pc=%h dec=%h want 1/3000/%h",
                      use_reset, out_valid, out_pc, act32, ref_decode(fw, 1'b0)); end
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    logic [63:0] q [$];
    logic [63:0] e;
    int c;
    c = 0;
    while (c < 500 && !(c >= 400 && q.size() == 0)) begin
      if (c < 400) begin
        in_valid  = ($urandom % 4) != 0;
        in_dword  = gen_word();
        in_pc     = $urandom & 32'hFFFF_FFFC;
        out_ready = ($urandom % 3) != 0;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      if (in_valid && in_ready) q.push_back({in_pc, in_dword});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL rand_spurious got pc=%h want none", out_pc);
        end else begin
          e = q.pop_front();
          total++; if (out_pc !== e[63:32] || act32 !== ref_decode(e[31:0], 1'b0)) begin
            bad++; $display("FAIL rand_stream word=%h got pc=%h dec=%h want pc=%h dec=%h",
                            e[31:0], out_pc, act32, e[63:32], ref_decode(e[31:0], 1'b0)); end
        end
      end
      @(negedge clk);
      c++;
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rand_lost got=%0d want=0", q.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_rv64();
    logic [31:0] w;
    logic [63:0] pc;
    out_ready64 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      w  = (i == 0) ? 32'hFFF00093 : (i == 1) ? 32'h0000B083 : gen_word();
      pc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
      in_valid64 = 1'b1; in_dword64 = w; in_pc64 = pc;
      @(negedge clk);
      in_valid64 = 1'b0;
      @(negedge clk);
      total++; if (out_valid64 !== 1'b1 || out_pc64 !== pc || act64 !== ref_decode(w, 1'b1)) begin
        bad++; $display("FAIL decode64[%0d] word=%h got valid=%b dec=%h want 1/%h",
                        i, w, out_valid64, act64, ref_decode(w, 1'b1)); end
      if (i == 0) begin
        total++; if (out_imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
          bad++; $display("FAIL addi64_imm got=%h want=ffffffffffffffff", out_imm64); end
      end
      if (i == 1) begin
        total++; if (out_illegal64 !== 1'b0 || out_width64 !== 3'b011) begin
          bad++; $display("FAIL ld64 got ill=%b width=%0d want 0/3", out_illegal64, out_width64); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_decode_table();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random_stream();
    test_rv64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
